// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, cache line, and the L2 arbiter state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } lc3b_l2_arb_state;

endpackage

// File: rtl/l2_arbiter.sv
// Two-port L2 arbiter: serialises I-cache reads and D-cache reads/writebacks
// onto the single L2 port. Ties are broken round-robin (RR_EN=1) or in favour
// of the D-cache (RR_EN=0). Requests pass straight through while granted, and
// a one-cycle RELEASE gap separates consecutive grants.
module l2_arbiter
    import lc3b_types::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          icache_read,
    input  lc3b_word      icache_address,
    output lc3b_cacheline icache_rdata,
    output logic          icache_resp,

    input  logic          dcache_read,
    input  logic          dcache_write,
    input  lc3b_word      dcache_address,
    input  lc3b_cacheline dcache_wdata,
    output lc3b_cacheline dcache_rdata,
    output logic          dcache_resp,

    output logic          mem_read,
    output logic          mem_write,
    output lc3b_word      mem_address,
    output lc3b_cacheline mem_wdata,
    input  lc3b_cacheline mem_rdata,
    input  logic          mem_resp
);

    lc3b_l2_arb_state state_q, state_d;
    // 0 = I-cache was served last, 1 = D-cache was served last
    logic             last_grant_q, last_grant_d;

    logic i_req;
    logic d_req;

    // Read and write together from the D-cache is illegal and counts as idle.
    assign i_req = icache_read;
    assign d_req = dcache_read ^ dcache_write;

    // State and last-grant registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: grant pick in IDLE, completion or abort while serving.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    if (RR_EN)
                        state_d = last_grant_q ? SERVE_I : SERVE_D;
                    else
                        state_d = SERVE_D;
                end else if (i_req) begin
                    state_d = SERVE_I;
                end else if (d_req) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I: begin
                // A response in the same cycle as a drop still counts as completion.
                if (mem_resp) begin
                    last_grant_d = 1'b0;
                    state_d      = RELEASE;
                end else if (!i_req) begin
                    state_d = RELEASE;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    last_grant_d = 1'b1;
                    state_d      = RELEASE;
                end else if (!d_req) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output routing: only the granted requester sees the L2 port; all else is 0.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        icache_resp  = 1'b0;
        icache_rdata = '0;
        dcache_resp  = 1'b0;
        dcache_rdata = '0;
        case (state_q)
            SERVE_I: begin
                mem_read     = i_req;
                mem_address  = i_req ? icache_address : '0;
                icache_resp  = mem_resp;
                icache_rdata = mem_rdata;
            end
            SERVE_D: begin
                mem_read     = dcache_read  & d_req;
                mem_write    = dcache_write & d_req;
                mem_address  = d_req ? dcache_address : '0;
                mem_wdata    = d_req ? dcache_wdata   : '0;
                dcache_resp  = mem_resp;
                dcache_rdata = mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: one round-robin instance and one fixed-priority
// instance share all inputs; each phase checks the instance it targets.
module tb_l2_arbiter;
    import lc3b_types::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          icache_read;
    lc3b_word      icache_address;
    logic          dcache_read;
    logic          dcache_write;
    lc3b_word      dcache_address;
    lc3b_cacheline dcache_wdata;
    lc3b_cacheline mem_rdata;
    logic          mem_resp;

    lc3b_cacheline r_icache_rdata, r_dcache_rdata, r_mem_wdata;
    logic          r_icache_resp, r_dcache_resp, r_mem_read, r_mem_write;
    lc3b_word      r_mem_address;

    lc3b_cacheline f_icache_rdata, f_dcache_rdata, f_mem_wdata;
    logic          f_icache_resp, f_dcache_resp, f_mem_read, f_mem_write;
    lc3b_word      f_mem_address;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l2_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(r_icache_rdata), .icache_resp(r_icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(r_dcache_rdata), .dcache_resp(r_dcache_resp),
        .mem_read(r_mem_read), .mem_write(r_mem_write),
        .mem_address(r_mem_address), .mem_wdata(r_mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    l2_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(f_icache_rdata), .icache_resp(f_icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(f_dcache_rdata), .dcache_resp(f_dcache_resp),
        .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_address(f_mem_address), .mem_wdata(f_mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_read    = 1'b0;
        icache_address = '0;
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = '0;
        dcache_wdata   = '0;
        mem_rdata      = '0;
        mem_resp       = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    lc3b_cacheline dead_line;
    lc3b_cacheline a5_line;
    lc3b_cacheline line_k;

    initial begin
        dead_line = {4{32'hDEADBEEF}};
        a5_line   = {16{8'hA5}};
        rst = 1'b1;
        clear_inputs();

        // ---- reset state ----
        do_reset();
        #1;
        check_val("rst_state", 128'(dut.state_q), 128'(IDLE));
        check_val("rst_mem_read", 128'(r_mem_read), 128'd0);
        check_val("rst_mem_write", 128'(r_mem_write), 128'd0);
        check_val("rst_mem_addr", 128'(r_mem_address), 128'd0);
        check_val("rst_i_resp", 128'(r_icache_resp), 128'd0);
        check_val("rst_d_resp", 128'(r_dcache_resp), 128'd0);

        // ---- I-read of 0x1230 ----
        icache_read    = 1'b1;
        icache_address = 16'h1230;
        #1;
        check_val("iread_idle_no_grant", 128'(r_mem_read), 128'd0);
        tick();
        check_val("iread_mem_read", 128'(r_mem_read), 128'd1);
        check_val("iread_mem_write", 128'(r_mem_write), 128'd0);
        check_val("iread_mem_addr", 128'(r_mem_address), 128'h1230);
        check_val("iread_wait_resp", 128'(r_icache_resp), 128'd0);
        tick();
        mem_resp  = 1'b1;
        mem_rdata = dead_line;
        #1;
        check_val("iread_i_resp", 128'(r_icache_resp), 128'd1);
        check_val("iread_i_rdata", r_icache_rdata, dead_line);
        check_val("iread_d_resp", 128'(r_dcache_resp), 128'd0);
        check_val("iread_d_rdata", r_dcache_rdata, 128'd0);
        tick();
        mem_resp    = 1'b0;
        mem_rdata   = '0;
        icache_read = 1'b0;
        #1;
        check_val("iread_release_read", 128'(r_mem_read), 128'd0);
        check_val("iread_release_state", 128'(dut.state_q), 128'(RELEASE));
        tick();

        // ---- D-write of 0x4000 ----
        do_reset();
        dcache_write   = 1'b1;
        dcache_address = 16'h4000;
        dcache_wdata   = a5_line;
        tick();
        for (int c = 0; c < 2; c++) begin
            check_val("dwr_mem_write", 128'(r_mem_write), 128'd1);
            check_val("dwr_mem_read", 128'(r_mem_read), 128'd0);
            check_val("dwr_mem_addr", 128'(r_mem_address), 128'h4000);
            check_val("dwr_mem_wdata", r_mem_wdata, a5_line);
            if (c == 0) tick();
        end
        mem_resp = 1'b1;
        #1;
        check_val("dwr_d_resp", 128'(r_dcache_resp), 128'd1);
        check_val("dwr_i_resp", 128'(r_icache_resp), 128'd0);
        tick();
        mem_resp = 1'b0;
        #1;
        // Requester still holds the write during RELEASE; port must stay quiet.
        check_val("dwr_rel_write", 128'(r_mem_write), 128'd0);
        check_val("dwr_rel_wdata", r_mem_wdata, 128'd0);
        check_val("dwr_rel_addr", 128'(r_mem_address), 128'd0);
        dcache_write = 1'b0;
        tick();
        check_val("dwr_back_idle", 128'(dut.state_q), 128'(IDLE));

        // ---- simultaneous I and D, round-robin: D, I, D, I, D, I ----
        do_reset();
        icache_read    = 1'b1;
        icache_address = 16'h1000;
        dcache_read    = 1'b1;
        dcache_address = 16'hD000;
        tick();
        for (int k = 0; k < 6; k++) begin
            line_k = {8{16'(k + 16'h0100)}};
            check_val("rr_mem_read", 128'(r_mem_read), 128'd1);
            check_val("rr_grant_addr", 128'(r_mem_address), (k % 2 == 0) ? 128'hD000 : 128'h1000);
            mem_resp  = 1'b1;
            mem_rdata = line_k;
            #1;
            check_val("rr_d_resp", 128'(r_dcache_resp), (k % 2 == 0) ? 128'd1 : 128'd0);
            check_val("rr_i_resp", 128'(r_icache_resp), (k % 2 == 0) ? 128'd0 : 128'd1);
            check_val("rr_rdata", (k % 2 == 0) ? r_dcache_rdata : r_icache_rdata, line_k);
            tick();
            mem_resp  = 1'b0;
            mem_rdata = '0;
            #1;
            check_val("rr_release_quiet", 128'(r_mem_read), 128'd0);
            tick();
            check_val("rr_idle_quiet", 128'(r_mem_read), 128'd0);
            tick();
        end

        // ---- same stimulus, fixed D priority ----
        do_reset();
        icache_read    = 1'b1;
        icache_address = 16'h1000;
        dcache_read    = 1'b1;
        dcache_address = 16'hD000;
        tick();
        for (int k = 0; k < 3; k++) begin
            check_val("fp_grant_d", 128'(f_mem_address), 128'hD000);
            mem_resp = 1'b1;
            #1;
            check_val("fp_d_resp", 128'(f_dcache_resp), 128'd1);
            check_val("fp_i_resp", 128'(f_icache_resp), 128'd0);
            tick();
            mem_resp = 1'b0;
            if (k == 2) dcache_read = 1'b0;
            tick();
            tick();
        end
        check_val("fp_i_after_d", 128'(f_mem_address), 128'h1000);
        check_val("fp_i_read", 128'(f_mem_read), 128'd1);
        mem_resp = 1'b1;
        #1;
        check_val("fp_i_resp_final", 128'(f_icache_resp), 128'd1);
        tick();
        mem_resp    = 1'b0;
        icache_read = 1'b0;
        tick();

        // ---- granted D aborts, pending I follows ----
        do_reset();
        icache_read    = 1'b1;
        icache_address = 16'h1000;
        dcache_read    = 1'b1;
        dcache_address = 16'h4444;
        tick();
        check_val("abort_grant_d", 128'(r_mem_address), 128'h4444);
        dcache_read = 1'b0;
        #1;
        check_val("abort_read_drop", 128'(r_mem_read), 128'd0);
        check_val("abort_no_d_resp", 128'(r_dcache_resp), 128'd0);
        tick();
        check_val("abort_release", 128'(dut.state_q), 128'(RELEASE));
        check_val("abort_rel_d_resp", 128'(r_dcache_resp), 128'd0);
        tick();
        check_val("abort_idle_quiet", 128'(r_mem_read), 128'd0);
        tick();
        check_val("abort_i_granted", 128'(r_mem_address), 128'h1000);
        check_val("abort_i_read", 128'(r_mem_read), 128'd1);
        mem_resp = 1'b1;
        #1;
        check_val("abort_i_resp", 128'(r_icache_resp), 128'd1);
        tick();
        mem_resp    = 1'b0;
        icache_read = 1'b0;
        tick();

        // ---- reset mid-SERVE_I, then first tie goes to D ----
        do_reset();
        icache_read    = 1'b1;
        icache_address = 16'h1230;
        tick();
        check_val("midrst_serving", 128'(r_mem_read), 128'd1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = dead_line;
        #1;
        check_val("midrst_state", 128'(dut.state_q), 128'(IDLE));
        check_val("midrst_mem_read", 128'(r_mem_read), 128'd0);
        check_val("midrst_mem_addr", 128'(r_mem_address), 128'd0);
        check_val("midrst_idle_resp_ignored", 128'(r_icache_resp), 128'd0);
        check_val("midrst_idle_rdata", r_icache_rdata, 128'd0);
        mem_resp       = 1'b0;
        mem_rdata      = '0;
        dcache_read    = 1'b1;
        dcache_address = 16'h2222;
        tick();
        check_val("midrst_tie_to_d", 128'(r_mem_address), 128'h2222);
        check_val("midrst_tie_state", 128'(dut.state_q), 128'(SERVE_D));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
